// File: rtl/correlator_pkg.sv
// correlator_pkg: shared correlator defaults, readout state encoding and index-width helper
package correlator_pkg;
    localparam int DEFAULT_MAX_DELAY = 501;
    localparam int DEFAULT_RESOLUTION = 32;
    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SAMPLE = 3'd1;
    localparam logic [2:0] S_SEND = 3'd2;
    localparam logic [2:0] S_CLEAR = 3'd3;
    localparam logic [2:0] S_WAIT_ZERO = 3'd4;
    typedef enum logic [2:0] {
        IDLE = S_IDLE,
        SAMPLE = S_SAMPLE,
        SEND = S_SEND,
        CLEAR = S_CLEAR,
        WAIT_ZERO = S_WAIT_ZERO
    } state_t;
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction
endpackage

// File: rtl/bin_select.sv
// bin_select: registered MAX_DELAY:1 mux picking one histogram bin off the packed bus
module bin_select import correlator_pkg::*; #(
    parameter int MAX_DELAY = DEFAULT_MAX_DELAY,
    parameter int RESOLUTION = DEFAULT_RESOLUTION,
    localparam int IDX_W = idx_w(MAX_DELAY)
) (
    input logic clk,
    input logic [RESOLUTION*MAX_DELAY-1:0] hist,
    input logic [IDX_W-1:0] sel,
    output logic [RESOLUTION-1:0] bin
);
    always_ff @(posedge clk) bin <= hist[int'(sel)*RESOLUTION +: RESOLUTION];
endmodule

// File: rtl/correlator_readout.sv
// correlator_readout: debounced bin-by-bin histogram dump over valid/ready with optional clear
module correlator_readout import correlator_pkg::*; #(
    parameter int MAX_DELAY = DEFAULT_MAX_DELAY,
    parameter int RESOLUTION = DEFAULT_RESOLUTION,
    parameter int STABLE_READS = 2,
    parameter int MAX_RETRY = 16,
    parameter int CLEAR_CYCLES = 4,
    localparam int IDX_W = idx_w(MAX_DELAY)
) (
    input logic clk,
    input logic reset,
    input logic [RESOLUTION*MAX_DELAY-1:0] hist,
    input logic start,
    input logic clear_after,
    output logic [RESOLUTION-1:0] out_data,
    output logic [IDX_W-1:0] out_index,
    output logic out_last,
    output logic out_valid,
    input logic out_ready,
    output logic corr_reset,
    output logic busy,
    output logic done,
    output logic unstable
);
    localparam int CNT_MAX = (MAX_RETRY > CLEAR_CYCLES) ? MAX_RETRY : CLEAR_CYCLES;
    localparam int CNT_W = $clog2(CNT_MAX + 1);
    localparam int MATCH_W = $clog2(STABLE_READS + 1);
    localparam logic [IDX_W-1:0] LAST = IDX_W'(MAX_DELAY - 1);
    state_t state;
    logic clr_lat, accept, stable, timeout, hist_zero;
    logic [IDX_W-1:0] idx, idx_n;
    logic [RESOLUTION-1:0] bin, samp;
    logic [MATCH_W-1:0] match, match_n;
    logic [CNT_W-1:0] cnt, cnt_n;

    // the mux is steered by next idx so its register already holds bin[idx] in SAMPLE
    bin_select #(.MAX_DELAY(MAX_DELAY), .RESOLUTION(RESOLUTION)) u_sel (
        .clk(clk),
        .hist(hist),
        .sel(idx_n),
        .bin(bin)
    );

    always_comb begin
        accept = state == SEND && out_ready;
        idx_n = (state == IDLE && start) ? '0 : (accept && idx != LAST) ? idx + 1'b1 : idx;
        match_n = (match == '0 || bin != samp) ? MATCH_W'(1) : match + 1'b1;
        cnt_n = cnt + 1'b1;
        stable = int'(match_n) >= STABLE_READS;
        timeout = int'(cnt_n) >= MAX_RETRY;
        hist_zero = hist == '0;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
            clr_lat <= 1'b0;
            idx <= '0;
            samp <= '0;
            match <= '0;
            cnt <= '0;
            out_data <= '0;
            out_index <= '0;
            out_last <= 1'b0;
            out_valid <= 1'b0;
            corr_reset <= 1'b0;
            busy <= 1'b0;
            done <= 1'b0;
            unstable <= 1'b0;
        end else begin
            done <= 1'b0;
            idx <= idx_n;
            case (state)
                IDLE: if (start) begin
                    clr_lat <= clear_after;
                    unstable <= 1'b0;
                    match <= '0;
                    cnt <= '0;
                    busy <= 1'b1;
                    state <= SAMPLE;
                end
                SAMPLE: if (stable || timeout) begin
                    out_data <= bin;
                    out_index <= idx;
                    out_last <= idx == LAST;
                    out_valid <= 1'b1;
                    unstable <= unstable | !stable;
                    state <= SEND;
                end else begin
                    samp <= bin;
                    match <= match_n;
                    cnt <= cnt_n;
                end
                SEND: if (accept) begin
                    out_valid <= 1'b0;
                    match <= '0;
                    cnt <= '0;
                    if (idx != LAST) state <= SAMPLE;
                    else if (clr_lat) begin
                        corr_reset <= 1'b1;
                        state <= CLEAR;
                    end else begin
                        busy <= 1'b0;
                        done <= 1'b1;
                        state <= IDLE;
                    end
                end
                CLEAR: if (int'(cnt_n) >= CLEAR_CYCLES) begin
                    corr_reset <= 1'b0;
                    cnt <= '0;
                    state <= WAIT_ZERO;
                end else cnt <= cnt_n;
                // a histogram that never reads back as zero is flagged rather than waited on forever
                WAIT_ZERO: if (hist_zero || timeout) begin
                    unstable <= unstable | !hist_zero;
                    busy <= 1'b0;
                    done <= 1'b1;
                    state <= IDLE;
                end else cnt <= cnt_n;
                default: state <= IDLE;
            endcase
        end
    end
endmodule
